// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM external bus arbiter: FSM encodings,
// the stall-vector slot used by the bus stall request, and the timeout default.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_BUSY = 2'd1,
    INST_BUSY = 2'd2,
    RESP      = 2'd3
  } arb_state_e;

  // Slot of stallreq_for_bus inside the stall controller's request vector.
  localparam int STALL_BUS = 2;

  localparam int MAX_WAIT_DEFAULT = 255;

endpackage

// File: rtl/mem_bus_arbiter_wait_timer.sv
// Saturating wait counter for one bus transaction; timeout fires on the
// cycle the count would reach MAX_WAIT while still waiting.
module bus_wait_timer
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(MAX_WAIT))) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = enable && (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external bus between the MEM-stage data port
// (priority) and the IF-stage fetch port, one outstanding transaction at a time.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_done,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_done,
  output logic                bus_err,
  output logic                bus_req,
  output logic [DATA_W/8-1:0] bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  output logic                stallreq_for_bus
);

  arb_state_e state, state_next;
  logic       accept_data, accept_inst, busy, finish;
  logic       timeout, drop_q, dropping;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (data_req) begin
          state_next = DATA_BUSY;
        end else if (inst_req && !flush) begin
          state_next = INST_BUSY;
        end
      end
      DATA_BUSY, INST_BUSY: begin
        if (bus_ack || timeout) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept_data = 1'b0;
    accept_inst = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        accept_data = data_req;
        accept_inst = !data_req && inst_req && !flush;
      end
      DATA_BUSY, INST_BUSY: busy = 1'b1;
      default: ;
    endcase
  end

  assign finish   = busy && (bus_ack || timeout);
  // A flush arriving on the completing cycle must also suppress the fetch result.
  assign dropping = drop_q || flush;

  bus_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!busy),
    .enable  (busy && !bus_ack),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req    <= 1'b0;
      bus_we     <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      data_rdata <= '0;
      inst_rdata <= '0;
      data_done  <= 1'b0;
      inst_done  <= 1'b0;
      bus_err    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      data_done <= 1'b0;
      inst_done <= 1'b0;
      bus_err   <= 1'b0;

      if (accept_data) begin
        bus_req   <= 1'b1;
        bus_we    <= data_we;
        bus_addr  <= data_addr;
        bus_wdata <= data_wdata;
      end else if (accept_inst) begin
        bus_req   <= 1'b1;
        bus_we    <= '0;
        bus_addr  <= inst_addr;
        bus_wdata <= '0;
      end else if (finish) begin
        bus_req <= 1'b0;
      end

      if (finish && (state == DATA_BUSY)) begin
        data_done  <= 1'b1;
        bus_err    <= !bus_ack;
        data_rdata <= bus_ack ? bus_rdata : '0;
      end

      if (finish && (state == INST_BUSY)) begin
        inst_done  <= !dropping;
        bus_err    <= !bus_ack && !dropping;
        inst_rdata <= bus_ack ? bus_rdata : '0;
      end

      if ((state == INST_BUSY) && flush) begin
        drop_q <= 1'b1;
      end else if (state == RESP) begin
        drop_q <= 1'b0;
      end
    end
  end

  assign stallreq_for_bus = (data_req && !data_done) || (inst_req && !inst_done && !flush);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a latency-programmable bus slave,
// scoreboard queues for bus issue and port completion, table vectors plus corner sequences.
module tb_mem_bus_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        bus_err;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stallreq_for_bus;

  typedef struct {
    bit          is_data;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ack_data;
    int          ack_delay;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_latency;
  } vec_t;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wdata;
  } bus_exp_t;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
    bit          err;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  bus_exp_t  mon_b;
  done_exp_t mon_d;
  vec_t      vecs[6];

  int test_count = 0;
  int fail_count = 0;
  int cyc        = 0;
  int rise_cnt   = 0;
  int last_rise  = 0;
  int prev_rise  = 0;
  int exp_rises  = 0;
  bit prev_req   = 1'b0;

  int          ack_delay  = 0;
  int          resp_cnt   = 0;
  logic [31:0] resp_data  = '0;
  bit          auto_en    = 1'b1;
  bit          manual_ack = 1'b0;

  mem_bus_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .inst_req         (inst_req),
    .inst_addr        (inst_addr),
    .inst_rdata       (inst_rdata),
    .inst_done        (inst_done),
    .data_req         (data_req),
    .data_we          (data_we),
    .data_addr        (data_addr),
    .data_wdata       (data_wdata),
    .data_rdata       (data_rdata),
    .data_done        (data_done),
    .bus_err          (bus_err),
    .bus_req          (bus_req),
    .bus_we           (bus_we),
    .bus_addr         (bus_addr),
    .bus_wdata        (bus_wdata),
    .bus_rdata        (bus_rdata),
    .bus_ack          (bus_ack),
    .stallreq_for_bus (stallreq_for_bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Bus slave: acks on the ack_delay-th cycle that bus_req is seen high; 0 means never.
  always @(negedge clk) begin
    if (bus_req && auto_en) begin
      resp_cnt++;
      if ((ack_delay != 0) && (resp_cnt == ack_delay)) begin
        bus_ack   = 1'b1;
        bus_rdata = resp_data;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = 32'h0BAD0BAD;
      end
    end else begin
      resp_cnt  = 0;
      bus_ack   = manual_ack;
      bus_rdata = manual_ack ? resp_data : 32'h0BAD0BAD;
    end
  end

  // Scoreboard monitor: checks each bus issue and each completion pulse in order.
  always @(negedge clk) begin
    cyc++;
    if (bus_req && !prev_req) begin
      rise_cnt++;
      prev_rise = last_rise;
      last_rise = cyc;
      if (bus_q.size() == 0) begin
        checkOutput("unexpected bus_req rise", 32'(bus_req), 32'd0);
      end else begin
        mon_b = bus_q.pop_front();
        checkOutput("bus_addr", bus_addr, mon_b.addr);
        checkOutput("bus_we", 32'(bus_we), 32'(mon_b.we));
        if (mon_b.chk_wdata) checkOutput("bus_wdata", bus_wdata, mon_b.wdata);
      end
    end
    prev_req = bus_req;

    if (data_done || inst_done) begin
      if (done_q.size() == 0) begin
        checkOutput("unexpected done", {30'd0, data_done, inst_done}, 32'd0);
      end else begin
        mon_d = done_q.pop_front();
        checkOutput("data_done", 32'(data_done), 32'(mon_d.is_data));
        checkOutput("inst_done", 32'(inst_done), 32'(!mon_d.is_data));
        checkOutput("rdata", mon_d.is_data ? data_rdata : inst_rdata, mon_d.rdata);
        checkOutput("bus_err", 32'(bus_err), 32'(mon_d.err));
        checkOutput("bus_req at done", 32'(bus_req), 32'd0);
      end
    end else if (bus_err) begin
      checkOutput("bus_err without done", 32'(bus_err), 32'd0);
    end
  end

  task automatic applyStimulus(input vec_t v);
    if (v.is_data) begin
      data_req   = 1'b1;
      data_we    = v.we;
      data_addr  = v.addr;
      data_wdata = v.wdata;
    end else begin
      inst_req  = 1'b1;
      inst_addr = v.addr;
    end
  endtask

  task automatic run_vector(input vec_t v, input string name);
    bit got = 1'b0;
    @(negedge clk);
    ack_delay = v.ack_delay;
    resp_data = v.ack_data;
    bus_q.push_back('{v.is_data ? v.we : 4'b0, v.addr, v.wdata, v.is_data});
    done_q.push_back('{v.is_data, v.exp_rdata, v.exp_err});
    exp_rises++;
    applyStimulus(v);
    for (int i = 1; i <= MAX_WAIT + 20; i++) begin
      @(negedge clk);
      if (v.is_data ? data_done : inst_done) begin
        got = 1'b1;
        checkOutput({name, " latency"}, 32'(i), 32'(v.exp_latency));
        checkOutput({name, " stall at done"}, 32'(stallreq_for_bus), 32'd0);
        data_req = 1'b0;
        inst_req = 1'b0;
        break;
      end
      checkOutput({name, " stall while waiting"}, 32'(stallreq_for_bus), 32'd1);
    end
    if (!got) begin
      checkOutput({name, " done seen before cycle limit"}, 32'(got), 32'd1);
      data_req = 1'b0;
      inst_req = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    vec_t fv;

    rst = 1'b1; flush = 1'b0; inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = '0; data_addr = '0; data_wdata = '0;

    // is_data, we, addr, wdata, ack_data, ack_delay, exp_rdata, exp_err, exp_latency
    vecs[0] = '{1'b0, 4'h0, 32'hBFC00000, 32'h0,        32'h24080001, 2,   32'h24080001, 1'b0, 3};
    vecs[1] = '{1'b1, 4'h0, 32'h80000100, 32'h0,        32'hA5A50001, 1,   32'hA5A50001, 1'b0, 2};
    vecs[2] = '{1'b1, 4'h3, 32'h80000204, 32'h11223344, 32'h00000000, 3,   32'h00000000, 1'b0, 4};
    vecs[3] = '{1'b0, 4'h0, 32'hBFC00010, 32'h0,        32'h0F0F0F0F, 255, 32'h0F0F0F0F, 1'b0, 256};
    vecs[4] = '{1'b1, 4'h0, 32'h80000400, 32'h0,        32'h55555555, 0,   32'h00000000, 1'b1, 256};
    vecs[5] = '{1'b0, 4'h0, 32'hBFC00020, 32'h0,        32'h66666666, 0,   32'h00000000, 1'b1, 256};

    repeat (2) @(negedge clk);
    checkOutput("reset bus_req", 32'(bus_req), 32'd0);
    checkOutput("reset bus_addr", bus_addr, 32'd0);
    checkOutput("reset done/err", {29'd0, data_done, inst_done, bus_err}, 32'd0);
    checkOutput("reset stall", 32'(stallreq_for_bus), 32'd0);
    rst = 1'b0;

    // A fetch presented together with flush is neither accepted nor stalls.
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hBFC0FFFC; flush = 1'b1;
    checkOutput("flushed fetch stall", 32'(stallreq_for_bus), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("flushed fetch not accepted", 32'(bus_req), 32'd0);
    inst_req = 1'b0; flush = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run_vector(vecs[k], $sformatf("vec%0d", k));
    end

    // Flush while the fetch is on the bus: the ack is consumed but no inst_done.
    @(negedge clk);
    ack_delay = 4; resp_data = 32'h12345678;
    bus_q.push_back('{4'b0, 32'hBFC00040, 32'h0, 1'b0});
    exp_rises++;
    inst_req = 1'b1; inst_addr = 32'hBFC00040;
    @(negedge clk);
    flush = 1'b1; inst_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("bus idle after flushed fetch", 32'(bus_req), 32'd0);
    fv = '{1'b0, 4'h0, 32'hBFC00044, 32'h0, 32'h3C1DBFC0, 1, 32'h3C1DBFC0, 1'b0, 2};
    run_vector(fv, "fetch after flush");

    // Simultaneous requests: data first, fetch after one idle cycle.
    @(negedge clk);
    ack_delay = 1; resp_data = 32'hCAFEF00D;
    bus_q.push_back('{4'hF, 32'h80000010, 32'hDEADBEEF, 1'b1});
    bus_q.push_back('{4'h0, 32'hBFC00004, 32'h0, 1'b0});
    done_q.push_back('{1'b1, 32'hCAFEF00D, 1'b0});
    done_q.push_back('{1'b0, 32'hCAFEF00D, 1'b0});
    exp_rises += 2;
    data_req = 1'b1; data_we = 4'hF; data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (data_done) begin
        checkOutput("stall with fetch pending", 32'(stallreq_for_bus), 32'd1);
        data_req = 1'b0;
      end
      if (inst_done) begin
        inst_req = 1'b0;
        got = 1'b1;
        break;
      end
    end
    checkOutput("back-to-back fetch completed", 32'(got), 32'd1);
    checkOutput("bus_req rise spacing", 32'(last_rise - prev_rise), 32'd3);

    // Reset in the middle of a data read abandons it; a late ack is ignored.
    @(negedge clk);
    ack_delay = 0;
    bus_q.push_back('{4'h0, 32'h80000300, 32'h0, 1'b1});
    exp_rises++;
    data_req = 1'b1; data_we = 4'h0; data_addr = 32'h80000300; data_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1; data_req = 1'b0;
    @(negedge clk);
    checkOutput("rst bus_req", 32'(bus_req), 32'd0);
    checkOutput("rst bus_we", 32'(bus_we), 32'd0);
    checkOutput("rst bus_addr", bus_addr, 32'd0);
    checkOutput("rst bus_wdata", bus_wdata, 32'd0);
    checkOutput("rst data_rdata", data_rdata, 32'd0);
    checkOutput("rst inst_rdata", inst_rdata, 32'd0);
    checkOutput("rst done/err", {29'd0, data_done, inst_done, bus_err}, 32'd0);
    rst = 1'b0;
    auto_en = 1'b0;
    @(posedge clk); #1;
    resp_data = 32'h77777777; manual_ack = 1'b1;
    @(posedge clk); #1;
    manual_ack = 1'b0;
    repeat (3) @(negedge clk);
    auto_en = 1'b1;
    checkOutput("bus idle after reset and stray ack", 32'(bus_req), 32'd0);
    fv = '{1'b1, 4'h4, 32'h80000500, 32'h00AB0000, 32'h00000000, 2, 32'h00000000, 1'b0, 3};
    run_vector(fv, "store after reset");

    repeat (3) @(negedge clk);
    checkOutput("bus_req rise count", 32'(rise_cnt), 32'(exp_rises));
    checkOutput("pending bus expectations", 32'(bus_q.size()), 32'd0);
    checkOutput("pending done expectations", 32'(done_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external SRAM-like bus between the IF-stage instruction fetch port and the MEM-stage data port.
- Sequences each transaction: grant, wait for ack, return data, one-cycle completion pulse.
- Drives `stallreq_for_bus` into the pipeline stall controller so the pipeline freezes while a port waits.
- Data port has strict priority over instruction port, because the MEM-stage access is the older instruction.

Parameters:
- ADDR_W, 32, address width of both ports and the bus
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_WAIT, 255, bus cycles without ack before abort; counter width is clog2(MAX_WAIT+1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- flush  in  1  pipeline flush; cancels the in-flight or arriving instruction fetch
- inst_req  in  1  fetch request; held high until inst_done
- inst_addr  in  ADDR_W  fetch address
- inst_rdata  out  DATA_W  fetched word; valid while inst_done=1
- inst_done  out  1  one-cycle completion pulse
- data_req  in  1  load/store request; held high until data_done
- data_we  in  DATA_W/8  byte write enables; 0 means read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load data; valid while data_done=1
- data_done  out  1  one-cycle completion pulse
- bus_err  out  1  one-cycle pulse together with done when a transaction times out
- bus_req  out  1  registered bus request
- bus_we  out  DATA_W/8  registered byte enables
- bus_addr  out  ADDR_W  registered address
- bus_wdata  out  DATA_W  registered write data
- bus_rdata  in  DATA_W  bus read data; valid with bus_ack
- bus_ack  in  1  bus completion; may arrive 1..N cycles after bus_req rises
- stallreq_for_bus  out  1  combinational stall request to the stall controller

Behaviour:
- Reset: rst is synchronous, active-high.
  - FSM goes to IDLE.
  - All registered outputs clear to 0: bus_*, *_rdata, *_done, bus_err.
  - Wait counter and drop flag clear to 0.
  - Reset mid-transaction abandons it silently; no done pulse.
- FSM states: IDLE, DATA_BUSY, INST_BUSY, RESP.
- IDLE:
  - data_req=1 → latch data_we/addr/wdata onto bus_*, set bus_req=1, go DATA_BUSY.
  - Else inst_req=1 and flush=0 → latch inst_addr with bus_we=0, set bus_req=1, go INST_BUSY.
  - A request arriving with flush=1 is not accepted that cycle.
- First bus_req is seen one cycle after the request is accepted (registered). Bus outputs hold stable while BUSY.
- DATA_BUSY / INST_BUSY, each cycle:
  - If bus_ack=1: capture bus_rdata into the owning port's rdata register, drop bus_req, go RESP, and assert that port's done during the RESP cycle.
  - Else increment the wait counter. When it reaches MAX_WAIT, drop bus_req, go RESP, pulse done together with bus_err; rdata = 0.
- INST_BUSY with flush=1 (or flush seen earlier in the transaction): set the drop flag.
  - The bus transaction still completes (or times out).
  - In RESP, inst_done and bus_err stay 0.
  - The drop flag clears on leaving RESP.
- Flush never affects DATA_BUSY.
- RESP lasts exactly one cycle.
  - Requests are ignored in RESP, so the requester drops req on the edge after it sees done.
  - Counter clears; FSM returns to IDLE.
- Minimum transaction latency: request to done = 3 cycles (accept, ack, RESP).
- Back-to-back: IDLE with both requests → data first; inst is served after RESP→IDLE, one idle cycle later.
- stallreq_for_bus = (data_req & ~data_done) | (inst_req & ~inst_done & ~flush).
- Only one transaction is ever outstanding on the bus.
- bus_ack in IDLE or RESP is ignored.

Decomposition:
- Shared defines header holds:
  - FSM state encodings (2 bits)
  - StallBus index of the bus stall request
  - MAX_WAIT default
- One sub-module is natural: `bus_wait_timer`, the saturating wait counter with clear, enable and timeout output.
- The FSM and datapath latches stay in mem_bus_arbiter.

Test Plan:
- inst_req, inst_addr=0xBFC00000, bus_ack 2 cycles after bus_req with rdata=0x24080001 → bus_addr=0xBFC00000, bus_we=0, inst_done one cycle with inst_rdata=0x24080001; stallreq high until the done cycle.
- inst_req and data_req together, data_we=4'b1111, addr 0x80000010, wdata 0xDEADBEEF → data transaction first; then the fetch issues with one idle cycle between bus_req pulses.
- flush pulsed while INST_BUSY, ack later with 0x12345678 → no inst_done, bus returns to IDLE, next fetch accepted normally.
- No bus_ack for MAX_WAIT cycles on a data read → data_done and bus_err pulse together in the same cycle, data_rdata=0, bus_req low.
- rst asserted during DATA_BUSY, then bus_ack → no data_done, all outputs 0 the cycle after rst.
- Requester holds data_req into the RESP cycle → no duplicate transaction; exactly one bus_req rise.
